// File: rtl/dest_router.sv
// Routes each pushed word into one of four FIFOs, picked by the word's top two bits.
// Every queue has a registered read port, occupancy flags and shared sticky error flags.
module dest_router #(
    parameter int unsigned DATA_W    = 6,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_THRESH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop_P0,
    input  logic              pop_P1,
    input  logic              pop_P2,
    input  logic              pop_P3,
    output logic [DATA_W-1:0] data_out_P0,
    output logic [DATA_W-1:0] data_out_P1,
    output logic [DATA_W-1:0] data_out_P2,
    output logic [DATA_W-1:0] data_out_P3,
    output logic              valid_out_P0,
    output logic              valid_out_P1,
    output logic              valid_out_P2,
    output logic              valid_out_P3,
    output logic              almost_full_P0,
    output logic              almost_full_P1,
    output logic              almost_full_P2,
    output logic              almost_full_P3,
    output logic              full_P0,
    output logic              full_P1,
    output logic              full_P2,
    output logic              full_P3,
    output logic              empty_P0,
    output logic              empty_P1,
    output logic              empty_P2,
    output logic              empty_P3,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);

    logic [3:0]        pop_vec;
    logic [1:0]        dest;
    logic [DATA_W-1:0] dout_w [4];
    logic [CNT_W-1:0]  cnt_w  [4];
    logic [3:0]        valid_w;
    logic [3:0]        ovf_hit;
    logic [3:0]        unf_hit;
    logic              err_ovf_q, err_ovf_d;
    logic              err_unf_q, err_unf_d;

    assign pop_vec = {pop_P3, pop_P2, pop_P1, pop_P0};
    assign dest    = data_in[DATA_W-1 -: 2];

    for (genvar n = 0; n < 4; n++) begin : g_queue
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [DATA_W-1:0] mem_d [DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [DATA_W-1:0] dout_q, dout_d;
        logic              valid_q, valid_d;
        logic              push_hit, push_ok, pop_ok;

        assign push_hit = push_in && (dest == 2'(n));
        assign pop_ok   = pop_vec[n] && (cnt_q != '0);
        // A same-cycle pop frees the slot, so a full queue still accepts the push.
        assign push_ok  = push_hit && ((cnt_q != CNT_FULL) || pop_ok);

        assign ovf_hit[n] = push_hit && !push_ok;
        assign unf_hit[n] = pop_vec[n] && (cnt_q == '0);

        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            dout_d   = dout_q;
            valid_d  = pop_ok;
            cnt_d    = cnt_q;
            if (push_ok) begin
                mem_d[wr_ptr_q] = data_in;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                dout_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                dout_q   <= '0;
                valid_q  <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
                dout_q   <= dout_d;
                valid_q  <= valid_d;
            end
        end

        // Storage is left uninitialised; stale entries are unreachable once pointers clear.
        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end

        assign dout_w[n]  = dout_q;
        assign cnt_w[n]   = cnt_q;
        assign valid_w[n] = valid_q;
    end

    always_comb begin
        err_ovf_d = err_ovf_q | (|ovf_hit);
        err_unf_d = err_unf_q | (|unf_hit);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

    assign data_out_P0 = dout_w[0];
    assign data_out_P1 = dout_w[1];
    assign data_out_P2 = dout_w[2];
    assign data_out_P3 = dout_w[3];

    assign valid_out_P0 = valid_w[0];
    assign valid_out_P1 = valid_w[1];
    assign valid_out_P2 = valid_w[2];
    assign valid_out_P3 = valid_w[3];

    assign almost_full_P0 = (cnt_w[0] >= CNT_AF);
    assign almost_full_P1 = (cnt_w[1] >= CNT_AF);
    assign almost_full_P2 = (cnt_w[2] >= CNT_AF);
    assign almost_full_P3 = (cnt_w[3] >= CNT_AF);

    assign full_P0 = (cnt_w[0] == CNT_FULL);
    assign full_P1 = (cnt_w[1] == CNT_FULL);
    assign full_P2 = (cnt_w[2] == CNT_FULL);
    assign full_P3 = (cnt_w[3] == CNT_FULL);

    assign empty_P0 = (cnt_w[0] == '0);
    assign empty_P1 = (cnt_w[1] == '0);
    assign empty_P2 = (cnt_w[2] == '0);
    assign empty_P3 = (cnt_w[3] == '0);

endmodule

// File: tb/tb_dest_router.sv
// Bench for dest_router: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_dest_router;

    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_in;
    logic [DW-1:0] data_in;
    logic          pop_P0, pop_P1, pop_P2, pop_P3;
    logic [DW-1:0] data_out_P0, data_out_P1, data_out_P2, data_out_P3;
    logic          valid_out_P0, valid_out_P1, valid_out_P2, valid_out_P3;
    logic          almost_full_P0, almost_full_P1, almost_full_P2, almost_full_P3;
    logic          full_P0, full_P1, full_P2, full_P3;
    logic          empty_P0, empty_P1, empty_P2, empty_P3;
    logic          err_overflow, err_underflow;

    always #5 clk = ~clk;

    dest_router #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .push_in        (push_in),
        .data_in        (data_in),
        .pop_P0         (pop_P0),
        .pop_P1         (pop_P1),
        .pop_P2         (pop_P2),
        .pop_P3         (pop_P3),
        .data_out_P0    (data_out_P0),
        .data_out_P1    (data_out_P1),
        .data_out_P2    (data_out_P2),
        .data_out_P3    (data_out_P3),
        .valid_out_P0   (valid_out_P0),
        .valid_out_P1   (valid_out_P1),
        .valid_out_P2   (valid_out_P2),
        .valid_out_P3   (valid_out_P3),
        .almost_full_P0 (almost_full_P0),
        .almost_full_P1 (almost_full_P1),
        .almost_full_P2 (almost_full_P2),
        .almost_full_P3 (almost_full_P3),
        .full_P0        (full_P0),
        .full_P1        (full_P1),
        .full_P2        (full_P2),
        .full_P3        (full_P3),
        .empty_P0       (empty_P0),
        .empty_P1       (empty_P1),
        .empty_P2       (empty_P2),
        .empty_P3       (empty_P3),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow)
    );

    logic [DW-1:0] dout [4];
    logic [3:0]    vld, af, full, emp;
    assign dout[0] = data_out_P0;
    assign dout[1] = data_out_P1;
    assign dout[2] = data_out_P2;
    assign dout[3] = data_out_P3;
    assign vld  = {valid_out_P3, valid_out_P2, valid_out_P1, valid_out_P0};
    assign af   = {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0};
    assign full = {full_P3, full_P2, full_P1, full_P0};
    assign emp  = {empty_P3, empty_P2, empty_P1, empty_P0};

    int total = 0;
    int bad   = 0;

    // Reference model: one plain FIFO per destination plus expected registered outputs.
    logic [DW-1:0] mq [4][$];
    logic [DW-1:0] m_dout [4];
    logic [3:0]    m_vld;
    logic          m_ovf, m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic rst_n, input logic push, input logic [DW-1:0] d,
                              input logic [3:0] pop);
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                mq[n].delete();
                m_dout[n] = '0;
            end
            m_vld = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                automatic int sz   = mq[n].size();
                automatic bit take = pop[n] && (sz > 0);
                automatic bit mine = push && (int'(d[DW-1 -: 2]) == n);
                m_vld[n] = take;
                if (take) m_dout[n] = mq[n].pop_front();
                if (pop[n] && sz == 0) m_unf = 1'b1;
                if (mine) begin
                    if (sz < DEPTH || take) mq[n].push_back(d);
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int n = 0; n < 4; n++) begin
            automatic int sz = mq[n].size();
            chk($sformatf("data_out_P%0d", n), 32'(dout[n]), 32'(m_dout[n]));
            chk($sformatf("valid_out_P%0d", n), 32'(vld[n]), 32'(m_vld[n]));
            chk($sformatf("almost_full_P%0d", n), 32'(af[n]), 32'(sz >= AF));
            chk($sformatf("full_P%0d", n), 32'(full[n]), 32'(sz == DEPTH));
            chk($sformatf("empty_P%0d", n), 32'(emp[n]), 32'(sz == 0));
        end
        chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
        chk("err_underflow", 32'(err_underflow), 32'(m_unf));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare at the falling edge.
    task automatic cycle(input logic rst_n, input logic push, input logic [DW-1:0] d,
                         input logic [3:0] pop);
        reset   = rst_n;
        push_in = push;
        data_in = d;
        {pop_P3, pop_P2, pop_P1, pop_P0} = pop;
        @(posedge clk);
        model_step(rst_n, push, d, pop);
        @(negedge clk);
        compare_all();
    endtask

    task automatic push1(input logic [DW-1:0] d);
        cycle(1'b1, 1'b1, d, 4'b0000);
    endtask

    task automatic pop1(input int n);
        cycle(1'b1, 1'b0, '0, 4'(1 << n));
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, '0, 4'b0000);
    endtask

    initial begin
        reset   = 1'b0;
        push_in = 1'b0;
        data_in = '0;
        {pop_P3, pop_P2, pop_P1, pop_P0} = 4'b0000;
        @(negedge clk);
        do_reset();
        chk("rst_empty", 32'(emp), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_dout3", 32'(data_out_P3), 32'h0);

        // Single word to queue 3
        push1(6'h31);
        chk("q3_push_empty", 32'(emp), 32'h7);
        pop1(3);
        chk("q3_pop_data", 32'(data_out_P3), 32'h31);
        chk("q3_pop_valid", 32'(valid_out_P3), 32'h1);
        chk("q3_pop_empty", 32'(empty_P3), 32'h1);
        cycle(1'b1, 1'b0, '0, 4'b0000);
        chk("q3_valid_drop", 32'(valid_out_P3), 32'h0);
        chk("q3_data_hold", 32'(data_out_P3), 32'h31);

        // Fill queue 0 through almost_full, full and overflow
        push1(6'h01);
        push1(6'h02);
        push1(6'h03);
        chk("q0_af", 32'(almost_full_P0), 32'h1);
        chk("q0_not_full", 32'(full_P0), 32'h0);
        push1(6'h04);
        chk("q0_full", 32'(full_P0), 32'h1);
        chk("q0_no_ovf_yet", 32'(err_overflow), 32'h0);
        push1(6'h05);
        chk("q0_ovf", 32'(err_overflow), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            pop1(0);
            chk($sformatf("q0_order%0d", i), 32'(data_out_P0), 32'(i));
        end
        chk("q0_ovf_sticky", 32'(err_overflow), 32'h1);

        // Push into a full queue with a same-cycle pop
        do_reset();
        for (int i = 0; i < 4; i++) push1(6'(8'h10 + i));
        cycle(1'b1, 1'b1, 6'h1A, 4'b0010);
        chk("q1_pp_data", 32'(data_out_P1), 32'h10);
        chk("q1_pp_full", 32'(full_P1), 32'h1);
        chk("q1_pp_no_ovf", 32'(err_overflow), 32'h0);
        pop1(1);
        pop1(1);
        pop1(1);
        pop1(1);
        chk("q1_last_1a", 32'(data_out_P1), 32'h1A);

        // Pop on empty while pushing: no bypass
        cycle(1'b1, 1'b1, 6'h2B, 4'b0100);
        chk("q2_no_bypass", 32'(valid_out_P2), 32'h0);
        chk("q2_unf", 32'(err_underflow), 32'h1);
        pop1(2);
        chk("q2_data", 32'(data_out_P2), 32'h2B);

        // Pointer wrap on queue 0
        do_reset();
        for (int i = 0; i < 10; i++) begin
            push1(6'(i));
            pop1(0);
            chk($sformatf("wrap%0d", i), 32'(data_out_P0), 32'(i));
        end

        // Reset wins over same-cycle push and pop
        push1(6'h20);
        push1(6'h21);
        push1(6'h22);
        cycle(1'b0, 1'b1, 6'h23, 4'b0100);
        chk("rst_prio_empty", 32'(emp), 32'hF);
        chk("rst_prio_valid", 32'(valid_out_P2), 32'h0);
        chk("rst_prio_unf", 32'(err_underflow), 32'h0);
        pop1(2);
        chk("rst_prio_stale", 32'(valid_out_P2), 32'h0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            automatic logic          r  = ($urandom_range(0, 99) != 0);
            automatic logic          p  = ($urandom_range(0, 3) != 0);
            automatic logic [DW-1:0] d  = DW'($urandom);
            automatic logic [3:0]    pv = 4'($urandom) & 4'($urandom);
            cycle(r, p, d, pv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dest_router.md
DEST_ROUTER -- requirements
Module: dest_router

Interface
REQ-001 Parameter DATA_W, default 6: word width; destination field is data_in[DATA_W-1:DATA_W-2].
REQ-002 Parameter DEPTH, default 4: entries per output queue; power of 2, >= 2.
REQ-003 Parameter AF_THRESH, default 3: occupancy at which almost_full asserts; range 1..DEPTH.
REQ-004 clk  input  1  clock, all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low; state clears on a rising edge with reset=0.
REQ-006 push_in  input  1  write strobe from the arbiter; one word per cycle.
REQ-007 data_in  input  DATA_W  word to route; sampled when push_in=1.
REQ-008 pop_P0..pop_P3  input  1 each  read strobe from downstream consumer of queue n.
REQ-009 data_out_P0..data_out_P3  output  DATA_W each  registered read data of queue n.
REQ-010 valid_out_P0..valid_out_P3  output  1 each  data_out_Pn holds a freshly popped word this cycle.
REQ-011 almost_full_P0..almost_full_P3  output  1 each  queue n occupancy >= AF_THRESH; backpressure to arbiter.
REQ-012 full_P0..full_P3  output  1 each  queue n occupancy == DEPTH.
REQ-013 empty_P0..empty_P3  output  1 each  queue n occupancy == 0.
REQ-014 err_overflow, err_underflow  output  1 each  sticky error flags.

Function
REQ-015 Four independent circular queues, each with write pointer, read pointer (log2(DEPTH) bits) and occupancy counter (log2(DEPTH)+1 bits).
REQ-016 Routing: push_in=1 targets queue n = data_in[DATA_W-1:DATA_W-2]; word stored unmodified (destination bits retained).
REQ-017 Accepted push: word written at wr_ptr, wr_ptr increments, wrapping DEPTH-1 -> 0.
REQ-018 Push to a full queue with no same-cycle pop on that queue: word dropped, pointers and count unchanged, err_overflow set.
REQ-019 Accepted pop (pop_Pn=1, queue n not empty): data_out_Pn <= entry at rd_ptr, valid_out_Pn <= 1 next edge, rd_ptr increments with wrap; read latency exactly 1 cycle.
REQ-020 Pop on empty queue: ignored, no bypass of a same-cycle push, valid_out_Pn <= 0, data_out_Pn holds, err_underflow set.
REQ-021 valid_out_Pn <= 0 on any cycle without an accepted pop on queue n; data_out_Pn holds last value.
REQ-022 Simultaneous accepted push and pop on same queue: both performed, count unchanged; applies when full (pop frees the slot, push accepted, no overflow).
REQ-023 Count: +1 push only, -1 pop only, unchanged both or neither; never exceeds DEPTH nor goes below 0.
REQ-024 Flags almost_full/full/empty are combinational from registered counts only; they reflect state after the last edge, no combinational path from any input.
REQ-025 Pops on different queues in the same cycle are independent; all may complete together.
REQ-026 err_overflow and err_underflow remain set until reset.

Reset
REQ-027 Reset=0 at a clock edge: all pointers and counts 0, data_out_Pn=0, valid_out_Pn=0, err flags 0; empty_Pn=1, full_Pn=0, almost_full_Pn=0 thereafter.
REQ-028 Reset has priority over push_in and pop_Pn in the same cycle; in-flight queue contents are discarded, no partial write.
REQ-029 Queue storage need not be cleared by reset; it is unobservable until rewritten.

Verification
REQ-030 Reset, then push 6'h31 (dest 3) -> count3=1, empty_P3=0, empty_P0..P2=1; pop_P3 next cycle -> data_out_P3=6'h31, valid_out_P3=1 one cycle later, empty_P3=1.
REQ-031 Push 6'h01,6'h02,6'h03 to queue 0 -> almost_full_P0=1 after third edge; fourth push 6'h04 -> full_P0=1; fifth push 6'h05 -> dropped, err_overflow=1; pops return 01,02,03,04 in order.
REQ-032 Queue 1 full (4 words), push 6'h1A with pop_P1 same cycle -> oldest word out, 6'h1A accepted, full_P1 stays 1, err_overflow=0.
REQ-033 Pop_P2 on empty queue while pushing 6'h2B -> valid_out_P2=0, err_underflow=1; next cycle pop_P2 -> data_out_P2=6'h2B.
REQ-034 Ten push/pop pairs on queue 0 with values 0..9 -> pointer wrap exercised, data returned 0..9 in order, count never > 1.
REQ-035 Queue 2 holding 3 words, reset=0 with push_in=1 and pop_P2=1 same cycle -> all empty=1, valid_out_P2=0, errors 0; pre-reset words never appear.
